bsg_alu_pipelined: RTL and testbench

Parametrised, two-stage pipelined ALU with a valid/ready input handshake and a valid/yumi output handshake. It extends the 4-op combinational ALU to 8 ops: the original four, plus SUB, OR, signed set-less-than, and a stateful accumulate op. Every result carries zero/carry/overflow flags. It sits between an operand producer, such as a decode or issue stage, and a result consumer, such as writeback, and sustains one op per cycle.

---
 rtl/bsg_alu_pkg.sv | 18 +
 rtl/bsg_alu_core.sv | 34 +++
 rtl/bsg_alu_pipelined.sv | 73 +++++++
 tb/tb_bsg_alu_pipelined.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_alu_pkg.sv
// bsg_alu_pkg: op codes and flag bundle shared by the pipelined ALU and its core
package bsg_alu_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_XOR  = 3'b001,
    OP_NAND = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_OR   = 3'b101,
    OP_SLT  = 3'b110,
    OP_ACC  = 3'b111
  } bsg_alu_op_e;
  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } bsg_alu_flags_s;
endpackage

// File: rtl/bsg_alu_core.sv
// bsg_alu_core: combinational 8-op ALU with one adder shared by ADD/SUB/ACC
module bsg_alu_core
  import bsg_alu_pkg::*;
#(
  parameter int width_p = 32
) (
  input  bsg_alu_op_e          op_i,
  input  logic [width_p-1:0]   a_i,
  input  logic [width_p-1:0]   b_i,
  input  logic [width_p-1:0]   acc_i,
  output logic [width_p-1:0]   data_o,
  output bsg_alu_flags_s       flags_o
);
  logic [width_p-1:0] b_eff;
  logic [width_p:0]   sum;
  logic               arith;
  always_comb begin
    b_eff = op_i == OP_SUB ? ~b_i : op_i == OP_ACC ? acc_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + {{width_p{1'b0}}, op_i == OP_SUB};
    arith = op_i inside {OP_ADD, OP_SUB, OP_ACC};
    case (op_i)
      OP_AND:  data_o = a_i & b_i;
      OP_XOR:  data_o = a_i ^ b_i;
      OP_NAND: data_o = ~(a_i & b_i);
      OP_OR:   data_o = a_i | b_i;
      OP_SLT:  data_o = {{(width_p-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      default: data_o = sum[width_p-1:0];
    endcase
    flags_o.zero     = data_o == '0;
    flags_o.carry    = arith & sum[width_p];
    flags_o.overflow = arith & (a_i[width_p-1] == b_eff[width_p-1])
                             & (sum[width_p-1] != a_i[width_p-1]);
  end
endmodule

// File: rtl/bsg_alu_pipelined.sv
// bsg_alu_pipelined: two-stage ALU, valid/ready in, valid/yumi out, with accumulator
module bsg_alu_pipelined
  import bsg_alu_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                v_i,
  output logic                ready_o,
  input  bsg_alu_op_e         op_i,
  input  logic [width_p-1:0]  a_i,
  input  logic [width_p-1:0]  b_i,
  input  logic                acc_clear_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  output logic                zero_o,
  output logic                carry_o,
  output logic                overflow_o,
  input  logic                yumi_i
);
  logic               s0_v_q, s0_v_d, s1_v_q, s1_v_d;
  bsg_alu_op_e        op_q;
  logic [width_p-1:0] a_q, b_q, data_q, acc_q, acc_d, acc_eff, res;
  bsg_alu_flags_s     flags_q, flags;
  logic               s1_en, move, accept;
  assign s1_en   = !s1_v_q | yumi_i;
  assign move    = s0_v_q & s1_en;
  assign ready_o = !s0_v_q | s1_en;
  assign accept  = v_i & ready_o;
  // a clear in the same cycle as an ACC move is seen by that ACC
  assign acc_eff = acc_clear_i ? '0 : acc_q;
  assign acc_d   = (move && op_q == OP_ACC) ? res : acc_eff;
  assign s0_v_d  = accept | (s0_v_q & !move);
  assign s1_v_d  = move | (s1_v_q & !yumi_i);
  bsg_alu_core #(.width_p(width_p)) core (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .acc_i   (acc_eff),
    .data_o  (res),
    .flags_o (flags)
  );
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      s0_v_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
      acc_q   <= '0;
    end else begin
      s0_v_q <= s0_v_d;
      s1_v_q <= s1_v_d;
      acc_q  <= acc_d;
      if (accept) begin
        op_q <= op_i;
        a_q  <= a_i;
        b_q  <= b_i;
      end
      if (move) begin
        data_q  <= res;
        flags_q <= flags;
      end
    end
  assign v_o        = s1_v_q;
  assign data_o     = data_q;
  assign zero_o     = flags_q.zero;
  assign carry_o    = flags_q.carry;
  assign overflow_o = flags_q.overflow;
endmodule

// File: tb/tb_bsg_alu_pipelined.sv
// tb_bsg_alu_pipelined: directed + random checks against an arithmetic reference model
module tb_bsg_alu_pipelined;
  import bsg_alu_pkg::*;
  localparam int W = 8;
  logic clk = 0, reset_n = 1, v_i = 0, acc_clear = 0, yumi_en = 0;
  logic ready_o, v_o, zero_o, carry_o, overflow_o, yumi_i;
  bsg_alu_op_e op_i = OP_AND;
  logic [W-1:0] a_i = '0, b_i = '0, data_o;
  int errors = 0, checks = 0, popped = 0, macc = 0, cyc = 0;
  int tp_base = -1, tp_first = 0, tp_last = 0;
  typedef struct {
    logic [W-1:0] d;
    logic z, c, o;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign yumi_i = yumi_en & v_o;

  bsg_alu_pipelined #(.width_p(W)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .acc_clear_i(acc_clear), .v_o(v_o), .data_o(data_o),
    .zero_o(zero_o), .carry_o(carry_o), .overflow_o(overflow_o), .yumi_i(yumi_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return x > 127 ? x - 256 : x;
  endfunction

  function automatic logic ovf(input int s);
    return s > 127 || s < -128;
  endfunction

  function automatic exp_t model(input bsg_alu_op_e op, input int a, input int b);
    exp_t e;
    int r;
    r = 0; e.c = 0; e.o = 0;
    case (op)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_OR:   r = a | b;
      OP_SLT:  r = int'(sx(a) < sx(b));
      OP_ADD:  begin r = a + b; e.c = r > 255; e.o = ovf(sx(a) + sx(b)); end
      OP_SUB:  begin r = a - b; e.c = a >= b; e.o = ovf(sx(a) - sx(b)); end
      default: begin r = macc + a; e.c = r > 255; e.o = ovf(sx(macc) + sx(a)); macc = r & 255; end
    endcase
    e.d = r[W-1:0];
    e.z = e.d == 0;
    return e;
  endfunction

  always @(negedge clk)
    if (reset_n && v_o && yumi_i) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $error("FAIL extra_result observed=%0h expected=none", data_o);
      end else begin
        mon_e = q.pop_front();
        chk("data", data_o, mon_e.d);
        chk("zero", zero_o, mon_e.z);
        chk("carry", carry_o, mon_e.c);
        chk("overflow", overflow_o, mon_e.o);
        if (popped == tp_base) tp_first = cyc;
        tp_last = cyc;
        popped++;
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bsg_alu_op_e op, input int a, input int b);
    int n;
    n = 0;
    op_i = op; a_i = a[W-1:0]; b_i = b[W-1:0]; v_i = 1;
    while (!ready_o && n < 50) begin tick(); n++; end
    if (n == 50) begin
      checks++; errors++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    q.push_back(model(op, a, b));
    tick();
    v_i = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin tick(); n++; end
    if (n == 100) begin
      checks++; errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", q.size());
    end
    tick();
  endtask

  initial begin
    int p0;
    #1 reset_n = 0;
    #1;
    chk("rst_v_o", v_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_flags", {zero_o, carry_o, overflow_o}, 0);
    tick(); tick();
    @(negedge clk) reset_n = 1;
    tick();
    chk("ready_after_rst", ready_o, 1);
    yumi_en = 1;
    send(OP_ADD, 8'hFF, 8'h01);
    chk("lat_v_o_early", v_o, 0);
    tick();
    chk("lat_v_o", v_o, 1);
    chk("add_data", data_o, 8'h00);
    chk("add_flags", {zero_o, carry_o, overflow_o}, 3'b110);
    drain();
    send(OP_SUB, 8'h80, 8'h01);
    send(OP_SLT, 8'hFE, 8'h01);
    send(OP_NAND, 8'hF0, 8'hFF);
    drain();
    yumi_en = 0;
    p0 = popped;
    send(OP_ADD, 1, 1);
    send(OP_ADD, 2, 2);
    op_i = OP_ADD; a_i = 8'd3; b_i = 8'd3; v_i = 1;
    chk("bp_ready", ready_o, 0);
    tick(); tick(); tick();
    chk("bp_ready_held", ready_o, 0);
    chk("bp_v_o", v_o, 1);
    chk("bp_data_stable", data_o, 8'h02);
    q.push_back(model(OP_ADD, 3, 3));
    yumi_en = 1;
    tick();
    v_i = 0;
    drain();
    chk("bp_count", popped - p0, 3);
    acc_clear = 1; macc = 0;
    tick();
    acc_clear = 0;
    send(OP_ACC, 5, 0);
    send(OP_ACC, 7, 0);
    macc = 0;
    send(OP_ACC, 3, 0);
    acc_clear = 1;
    tick();
    acc_clear = 0;
    send(OP_ACC, 1, 0);
    drain();
    tp_base = popped;
    for (int i = 0; i < 16; i++)
      send(bsg_alu_op_e'(3'($urandom_range(0, 7))), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    drain();
    chk("tp_count", popped - tp_base, 16);
    chk("tp_consecutive", tp_last - tp_first, 15);
    tp_base = -1;
    yumi_en = 0;
    send(OP_ADD, 1, 2);
    send(OP_XOR, 8'h5A, 8'h0F);
    chk("pre_rst_v_o", v_o, 1);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_v_o", v_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_flags", {zero_o, carry_o, overflow_o}, 0);
    q.delete();
    macc = 0;
    @(negedge clk) reset_n = 1;
    tick();
    chk("post_rst_ready", ready_o, 1);
    yumi_en = 1;
    send(OP_ACC, 9, 0);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
